// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (requester 0)
// and the branch/compare helper (requester 1). Round-robin grant, operand
// hold for a per-opcode latency, registered result returned over a
// valid/ready response channel to whichever requester owns the operation.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a request; ready asserted to the granted requester
// EXEC  | operands held on the ALU, counter running down to capture
// RESP  | result registered, valid to the owner until it takes it
module alu_share_arbiter #(
    parameter int WIDTH      = 16,
    parameter int LAT_SIMPLE = 1,
    parameter int LAT_MULDIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_br,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_branch
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] LAT_S = 4'(LAT_SIMPLE);
    localparam logic [3:0] LAT_M = 4'(LAT_MULDIV);
    localparam logic [3:0] SEL_BEQ = 4'b1000;

    state_t           state_q, state_d;
    logic             last_grant_q;   // 1: requester 1 was granted last
    logic             owner_q;
    logic [3:0]       cnt_q;
    logic             grant0, grant1;
    logic [3:0]       acc_sel;
    logic [WIDTH-1:0] acc_a, acc_b;

    function automatic logic is_supported(input logic [3:0] sel);
        case (sel)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0101, 4'b0110, 4'b1000, 4'b1001, 4'b1010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Multiply and divide get the long latency; everything else, including
    // unsupported codes, runs for the simple latency.
    function automatic logic [3:0] lat_of(input logic [3:0] sel);
        return (sel == 4'b0010 || sel == 4'b0011) ? LAT_M : LAT_S;
    endfunction

    // Round-robin grant and the operand mux for the accepted request.
    always_comb begin
        grant0  = req0_valid && (!req1_valid || last_grant_q);
        grant1  = req1_valid && (!req0_valid || !last_grant_q);
        acc_sel = grant1 ? req1_sel : req0_sel;
        acc_a   = grant1 ? req1_a   : req0_a;
        acc_b   = grant1 ? req1_b   : req0_b;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q == 4'd0) state_d = RESP;
            end
            RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch on accept, execute countdown, and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= 4'd0;
            alu_sel      <= 4'd0;
            alu_in1      <= '0;
            alu_in2      <= '0;
            rsp_res      <= '0;
            rsp_br       <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            if (state_q == IDLE && (grant0 || grant1)) begin
                owner_q      <= grant1;
                last_grant_q <= grant1;
                alu_sel      <= acc_sel;
                alu_in1      <= acc_a;
                alu_in2      <= acc_b;
                cnt_q        <= lat_of(acc_sel) - 4'd1;
            end
            if (state_q == EXEC) begin
                if (cnt_q == 4'd0) begin
                    rsp_err <= !is_supported(alu_sel);
                    rsp_br  <= (alu_sel == SEL_BEQ) ? alu_branch : 1'b0;
                    rsp_res <= (!is_supported(alu_sel) || alu_sel == SEL_BEQ)
                               ? '0 : alu_res;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
        end
    end

endmodule
